// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order req/gnt reads to imem, and buffers
// returned words in a prefetch FIFO whose head (word, PC, op, funct) feeds the decoder.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  op,
  output logic [5:0]  funct
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] ZERO_A  = AW'(0);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  logic [31:0]   fpc, fpc_nxt;
  logic [31:0]   dpc, dpc_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [CW-1:0] live, live_nxt;
  logic [CW-1:0] drop, drop_nxt;
  logic [CW:0]   flush_drop;
  logic [SW-1:0] used;
  logic          grant;
  logic          push;
  logic          pop;

  // Every buffered, in-flight or to-be-dropped word holds one credit, so the FIFO can never overflow.
  assign used        = SW'(count) + SW'(live) + SW'(drop);
  assign imem_req    = reset & ~redirect & (used < DEPTH_S);
  assign imem_addr   = fpc;
  assign grant       = imem_req & imem_gnt;
  assign push        = imem_rvalid & (drop == ZERO_C) & (live != ZERO_C) & ~redirect;
  assign instr_valid = (count != ZERO_C);
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign instr       = instr_valid ? mem[rd_ptr] : 32'h0000_0000;
  assign instr_pc    = dpc;
  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign flush_drop  = {1'b0, drop} + {1'b0, live};

  // Next-state: redirect flushes the FIFO and turns every in-flight fetch into a dropped one.
  always_comb begin
    fpc_nxt    = fpc;
    dpc_nxt    = dpc;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    live_nxt   = live;
    drop_nxt   = drop;
    if (redirect) begin
      fpc_nxt    = redirect_pc;
      dpc_nxt    = redirect_pc;
      rd_ptr_nxt = ZERO_A;
      wr_ptr_nxt = ZERO_A;
      count_nxt  = ZERO_C;
      live_nxt   = ZERO_C;
      if (imem_rvalid && (flush_drop != (CW+1)'(0))) begin
        drop_nxt = CW'(flush_drop - (CW+1)'(1));
      end else begin
        drop_nxt = CW'(flush_drop);
      end
    end else begin
      fpc_nxt    = grant ? (fpc + 32'd4) : fpc;
      dpc_nxt    = pop ? (dpc + 32'd4) : dpc;
      rd_ptr_nxt = pop ? (rd_ptr + ONE_A) : rd_ptr;
      wr_ptr_nxt = push ? (wr_ptr + ONE_A) : wr_ptr;
      count_nxt  = count + (push ? ONE_C : ZERO_C) - (pop ? ONE_C : ZERO_C);
      live_nxt   = live + (grant ? ONE_C : ZERO_C) - (push ? ONE_C : ZERO_C);
      if (imem_rvalid && (drop != ZERO_C)) begin
        drop_nxt = drop - ONE_C;
      end else begin
        drop_nxt = drop;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc    <= RESET_PC;
      dpc    <= RESET_PC;
      rd_ptr <= ZERO_A;
      wr_ptr <= ZERO_A;
      count  <= ZERO_C;
      live   <= ZERO_C;
      drop   <= ZERO_C;
    end else begin
      fpc    <= fpc_nxt;
      dpc    <= dpc_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      live   <= live_nxt;
      drop   <= drop_nxt;
    end
  end

  // Prefetch FIFO storage; rdata is registered here, never passed straight through to instr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (push) begin
      mem[wr_ptr] <= imem_rdata;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  // A response must belong to an outstanding or dropping grant; a push into a full FIFO needs a pop.
  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> ((live != ZERO_C) || (drop != ZERO_C)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner-case sequences and random stalls,
// all checked against a queue-based model of buffered words and in-flight fetches.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  op;
  logic [5:0]  funct;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .op(op), .funct(funct)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rv;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        vecs [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pend [$];      // bench memory: granted addresses awaiting a response
  logic [31:0] m_fifo [$];    // model: buffered words, head first
  bit          m_infl [$];    // model: in-flight fetches, 1 = keep, 0 = to be discarded
  logic [31:0] m_fpc, m_dpc;
  bit          gnt_en, rv_en;
  bit          cur_rv, cur_mreq, cur_dut_grant;
  logic [31:0] cur_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect = 1'b0;
    gnt_en = 1'b0;
    rv_en = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    pend.delete();
    m_fifo.delete();
    m_infl.delete();
    m_fpc = RESET_PC;
    m_dpc = RESET_PC;
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, RESET_PC);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_opfunct", {20'h0, op, funct}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Drive memory side for this cycle, let logic settle, compare against the model.
  task automatic settle();
    logic [31:0] e_instr;
    imem_gnt = gnt_en;
    cur_rv = rv_en && (pend.size() > 0);
    imem_rvalid = cur_rv;
    imem_rdata = cur_rv ? mem_word(pend[0]) : 32'h0;
    #2;
    cur_mreq = !redirect && ((m_fifo.size() + m_infl.size()) < DEPTH);
    cur_dut_grant = imem_req && imem_gnt;
    cur_addr = imem_addr;
    e_instr = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
    chk("imem_req", {31'h0, imem_req}, {31'h0, cur_mreq});
    chk("imem_addr", imem_addr, m_fpc);
    chk("instr_valid", {31'h0, instr_valid}, {31'h0, (m_fifo.size() > 0)});
    chk("instr_pc", instr_pc, m_dpc);
    chk("instr", instr, e_instr);
    chk("op_funct", {20'h0, op, funct}, {20'h0, e_instr[31:26], e_instr[5:0]});
  endtask

  // Clock edge: advance bench memory and model by one cycle.
  task automatic advance();
    bit keep;
    @(posedge clk);
    if (cur_rv) void'(pend.pop_front());
    if (cur_dut_grant) pend.push_back(cur_addr);
    if (redirect) begin
      if (cur_rv && (m_infl.size() > 0)) void'(m_infl.pop_front());
      foreach (m_infl[i]) m_infl[i] = 1'b0;
      m_fifo.delete();
      m_fpc = redirect_pc;
      m_dpc = redirect_pc;
    end else begin
      if ((m_fifo.size() > 0) && instr_ready) begin
        void'(m_fifo.pop_front());
        m_dpc = m_dpc + 32'd4;
      end
      if (cur_rv && (m_infl.size() > 0)) begin
        keep = m_infl.pop_front();
        if (keep) m_fifo.push_back(imem_rdata);
      end
      if (cur_mreq && imem_gnt) begin
        m_infl.push_back(1'b1);
        m_fpc = m_fpc + 32'd4;
      end
    end
    #1;
  endtask

  function automatic void add(input bit rst, input bit gnt, input bit rv, input bit rdy,
                              input bit e_req, input logic [31:0] e_addr,
                              input bit e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    vecs.push_back(v);
  endfunction

  task automatic wait_valid_pc(input string name, input logic [31:0] pc);
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      settle();
      if (instr_valid) begin
        found = 1'b1;
        chk({name, "_pc"}, instr_pc, pc);
        chk({name, "_word"}, instr, mem_word(pc));
      end
      advance();
    end
    if (!found) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    int          ngr;
    logic [31:0] gaddr [2];

    // Streaming from reset, 1-cycle memory, ready=1.
    add(1, 1, 1, 1, 1, 32'd0,  0, 32'd0);
    add(0, 1, 1, 1, 1, 32'd4,  0, 32'd0);
    add(0, 1, 1, 1, 0, 32'd8,  1, 32'd0);
    add(0, 1, 1, 1, 1, 32'd8,  1, 32'd4);
    add(0, 1, 1, 1, 1, 32'd12, 0, 32'd8);
    add(0, 1, 1, 1, 0, 32'd16, 1, 32'd8);
    add(0, 1, 1, 1, 1, 32'd16, 1, 32'd12);
    // Consumer stalled: two grants fill credit, one pop frees one request at 8.
    add(1, 1, 1, 0, 1, 32'd0,  0, 32'd0);
    add(0, 1, 1, 0, 1, 32'd4,  0, 32'd0);
    add(0, 1, 1, 0, 0, 32'd8,  1, 32'd0);
    add(0, 1, 1, 0, 0, 32'd8,  1, 32'd0);
    add(0, 1, 1, 1, 0, 32'd8,  1, 32'd0);
    add(0, 1, 1, 0, 1, 32'd8,  1, 32'd4);
    add(0, 1, 1, 0, 0, 32'd12, 1, 32'd4);
    add(0, 1, 1, 0, 0, 32'd12, 1, 32'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      gnt_en = vecs[i].gnt;
      rv_en = vecs[i].rv;
      instr_ready = vecs[i].rdy;
      settle();
      chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].e_pc);
      if (vecs[i].e_valid) chk($sformatf("vec%0d_word", i), instr, mem_word(vecs[i].e_pc));
      advance();
    end

    // Two grants outstanding, then redirect: both late responses must be dropped.
    do_reset();
    gnt_en = 1'b1; rv_en = 1'b0; instr_ready = 1'b1;
    repeat (3) begin settle(); advance(); end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    settle();
    chk("t3_req_on_redirect", {31'h0, imem_req}, 32'h0);
    advance();
    redirect = 1'b0; rv_en = 1'b1;
    wait_valid_pc("t3", 32'h0000_0100);

    // Redirect coinciding with rvalid and pop.
    do_reset();
    gnt_en = 1'b1; rv_en = 1'b1; instr_ready = 1'b1;
    repeat (2) begin settle(); advance(); end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    settle();
    chk("t4_pre_valid", {31'h0, instr_valid}, 32'h1);
    chk("t4_pre_rvalid", {31'h0, imem_rvalid}, 32'h1);
    advance();
    redirect = 1'b0;
    settle();
    chk("t4_no_valid", {31'h0, instr_valid}, 32'h0);
    chk("t4_dpc", instr_pc, 32'h0000_0100);
    advance();
    wait_valid_pc("t4", 32'h0000_0100);

    // Fetch PC wraps past the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    settle(); advance();
    redirect = 1'b0;
    ngr = 0;
    for (int k = 0; k < 20 && ngr < 2; k++) begin
      settle();
      if (cur_dut_grant) begin gaddr[ngr] = cur_addr; ngr++; end
      advance();
    end
    chk("t5_grants", ngr, 32'd2);
    chk("t5_addr0", gaddr[0], 32'hFFFF_FFFC);
    chk("t5_addr1", gaddr[1], 32'h0000_0000);

    // Random gnt/rvalid/ready stalls with occasional redirects.
    for (int k = 0; k < 1500; k++) begin
      gnt_en = ($urandom_range(0, 3) != 0);
      rv_en = ($urandom_range(0, 2) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      settle();
      advance();
    end
    redirect = 1'b0;

    // Reset mid-stream with two fetches outstanding.
    do_reset();
    gnt_en = 1'b1; rv_en = 1'b0; instr_ready = 1'b1;
    repeat (2) begin settle(); advance(); end
    settle();
    do_reset();
    gnt_en = 1'b1; rv_en = 1'b1;
    wait_valid_pc("t6", RESET_PC);
    repeat (6) begin settle(); advance(); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
